// File: rtl/rgb_frame_buffer.sv
// rgb_frame_buffer: one-frame, N-channel pixel buffer.
// The write side is a frame-sequenced stream with an auto-incrementing
// address driven by a 3-state FSM. The read side is random-access with a
// registered, valid-tagged output.
// Optional macro RGB_FRAME_BUFFER_BYPASS_EN: a same-cycle read and write to the
// same in-range address returns the incoming wr_data (write-first) instead of
// the stored word (read-first, the default build).
module rgb_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int N_CH       = 3,
    parameter int ADD_WIDTH  = 4,
    parameter int A_MAX      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_sof,
    input  logic                         wr_valid,
    input  logic [N_CH*DATA_WIDTH-1:0]   wr_data,
    output logic [ADD_WIDTH-1:0]         wr_addr_o,
    output logic                         frame_done,
    output logic                         frame_ready,
    output logic                         wr_overflow,
    input  logic                         rd_en,
    input  logic [ADD_WIDTH-1:0]         rd_addr,
    output logic [N_CH*DATA_WIDTH-1:0]   rd_data,
    output logic                         rd_valid
);

    localparam int                     PW        = N_CH * DATA_WIDTH;
    localparam logic [ADD_WIDTH-1:0]   LAST_ADDR = ADD_WIDTH'(A_MAX - 1);
    localparam logic [ADD_WIDTH:0]     DEPTH     = (ADD_WIDTH + 1)'(A_MAX);

    typedef enum logic [1:0] {
        IDLE,
        WRITING,
        FULL
    } wr_state_e;

    wr_state_e              state_q, state_d;
    logic [ADD_WIDTH-1:0]   addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   ovf_q, ovf_d;
    logic                   rd_valid_q;
    logic [PW-1:0]          rd_data_q, rd_data_d;

    logic                   wr_req;
    logic                   wr_en;
    logic [ADD_WIDTH-1:0]   wr_waddr;
    logic                   rd_in_range;

    logic [PW-1:0]          mem_q [A_MAX];

    // Write FSM next state, address sequencing and flag pulses.
    // wr_sof takes priority over the current state, including FULL.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        ready_d  = ready_q;
        ovf_d    = 1'b0;
        wr_req   = 1'b0;
        wr_waddr = addr_q;
        if (wr_sof) begin
            state_d = WRITING;
            addr_d  = '0;
            ready_d = 1'b0;
            if (wr_valid) begin
                wr_req   = 1'b1;
                wr_waddr = '0;
                if (LAST_ADDR == '0) begin
                    state_d = FULL;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    addr_d = ADD_WIDTH'(1);
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_valid) ovf_d = 1'b1;
                end
                WRITING: begin
                    if (wr_valid) begin
                        wr_req = 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            state_d = FULL;
                            done_d  = 1'b1;
                            ready_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADD_WIDTH'(1);
                        end
                    end
                end
                FULL: begin
                    if (wr_valid) ovf_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset blocks memory writes so a mid-frame reset leaves contents untouched.
    assign wr_en       = wr_req & ~rst;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH;

    // Read data selection: out-of-range reads return zero; hold when idle.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (!rd_in_range) begin
                rd_data_d = '0;
`ifdef RGB_FRAME_BUFFER_BYPASS_EN
            end else if (wr_en && (wr_waddr == rd_addr)) begin
                rd_data_d = wr_data;
`endif
            end else begin
                rd_data_d = mem_q[rd_addr];
            end
        end
    end

    // Write FSM, address and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    // Read output register; reset discards any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    // Pixel storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_waddr] <= wr_data;
    end

    assign wr_addr_o   = addr_q;
    assign frame_done  = done_q;
    assign frame_ready = ready_q;
    assign wr_overflow = ovf_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule
